// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared 64-bit ALU: arbitrates, registers operands,
// captures the ALU result and returns it to the owning requester.
module alu_arbiter #(
   parameter int FIXED_PRIO = 0
) (
   input  logic        CLK,
   input  logic        Reset_L,
   input  logic        ReqValid0,
   input  logic        ReqValid1,
   output logic        ReqReady0,
   output logic        ReqReady1,
   input  logic [63:0] ReqA0,
   input  logic [63:0] ReqB0,
   input  logic [63:0] ReqA1,
   input  logic [63:0] ReqB1,
   input  logic [3:0]  ReqCtrl0,
   input  logic [3:0]  ReqCtrl1,
   output logic        RspValid0,
   output logic        RspValid1,
   input  logic        RspReady0,
   input  logic        RspReady1,
   output logic [63:0] RspW,
   output logic        RspZero,
   output logic        RspErr,
   output logic [63:0] AluBusA,
   output logic [63:0] AluBusB,
   output logic [3:0]  AluCtrl,
   input  logic [63:0] AluBusW
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state, state_nxt;
   logic        rrptr;
   logic        owner;
   logic        grant;
   logic        accept;
   logic        rsp_hs;
   logic        supported;
   logic [63:0] opa, opb, rspw_q;
   logic [3:0]  opctrl;
   logic        zero_q, err_q;

   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      accept    = 1'b0;
      rsp_hs    = 1'b0;
      // grant is 1 when requester 1 wins
      if (ReqValid0 && ReqValid1) grant = (FIXED_PRIO == 1) ? 1'b0 : rrptr;
      else                        grant = ReqValid1;
      case (state)
         IDLE: begin
            accept = ReqValid0 || ReqValid1;
            if (accept) state_nxt = EXEC;
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            rsp_hs = owner ? RspReady1 : RspReady0;
            if (rsp_hs) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      ReqReady0 = accept && !grant && Reset_L;
      ReqReady1 = accept &&  grant && Reset_L;
      RspValid0 = (state == RESP) && !owner;
      RspValid1 = (state == RESP) &&  owner;
   end

   always_comb begin
      supported = 1'b0;
      case (opctrl)
         4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000: supported = 1'b1;
         default: supported = 1'b0;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         rrptr  <= 1'b0;
         owner  <= 1'b0;
         opa    <= '0;
         opb    <= '0;
         opctrl <= '0;
         rspw_q <= '0;
         zero_q <= 1'b1;
         err_q  <= 1'b0;
      end else begin
         if (accept) begin
            owner  <= grant;
            opa    <= grant ? ReqA1    : ReqA0;
            opb    <= grant ? ReqB1    : ReqB0;
            opctrl <= grant ? ReqCtrl1 : ReqCtrl0;
         end
         if (state == EXEC) begin
            // unsupported codes ignore whatever the ALU drives
            if (supported) begin
               rspw_q <= AluBusW;
               zero_q <= (AluBusW == '0);
               err_q  <= 1'b0;
            end else begin
               rspw_q <= '0;
               zero_q <= 1'b1;
               err_q  <= 1'b1;
            end
         end
         if (rsp_hs) rrptr <= ~owner;
      end
   end

   assign AluBusA = opa;
   assign AluBusB = opb;
   assign AluCtrl = opctrl;
   assign RspW    = rspw_q;
   assign RspZero = zero_q;
   assign RspErr  = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: round-robin and fixed-priority instances driven in parallel,
// each with its own behavioural ALU, checked against a transaction-level model.
module tb_alu_arbiter;

   logic        CLK = 1'b0;
   logic        Reset_L;
   logic        ReqValid0, ReqValid1, RspReady0, RspReady1;
   logic [63:0] ReqA0, ReqB0, ReqA1, ReqB1;
   logic [3:0]  ReqCtrl0, ReqCtrl1;

   logic        p0_rdy0, p0_rdy1, p0_rv0, p0_rv1, p0_zero, p0_err;
   logic [63:0] p0_w, p0_a, p0_b, p0_aluw;
   logic [3:0]  p0_ctrl;
   logic        p1_rdy0, p1_rdy1, p1_rv0, p1_rv1, p1_zero, p1_err;
   logic [63:0] p1_w, p1_a, p1_b, p1_aluw;
   logic [3:0]  p1_ctrl;

   int checks = 0;
   int failures = 0;
   bit pref = 1'b0;

   always #5 CLK = ~CLK;

   // shared-ALU model; unsupported codes drive junk the arbiter must ignore
   function automatic logic [63:0] alu_model(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
      case (c)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0111: return b;
         4'b1000: return ~b;
         default: return a ^ b ^ 64'hDEAD_BEEF_0BAD_F00D;
      endcase
   endfunction

   function automatic void ref_op(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] w, output logic err);
      err = !(c inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000});
      w   = err ? 64'd0 : alu_model(c, a, b);
   endfunction

   assign p0_aluw = alu_model(p0_ctrl, p0_a, p0_b);
   assign p1_aluw = alu_model(p1_ctrl, p1_a, p1_b);

   alu_arbiter #(.FIXED_PRIO(0)) u_rr (
      .CLK(CLK), .Reset_L(Reset_L),
      .ReqValid0(ReqValid0), .ReqValid1(ReqValid1), .ReqReady0(p0_rdy0), .ReqReady1(p0_rdy1),
      .ReqA0(ReqA0), .ReqB0(ReqB0), .ReqA1(ReqA1), .ReqB1(ReqB1),
      .ReqCtrl0(ReqCtrl0), .ReqCtrl1(ReqCtrl1),
      .RspValid0(p0_rv0), .RspValid1(p0_rv1), .RspReady0(RspReady0), .RspReady1(RspReady1),
      .RspW(p0_w), .RspZero(p0_zero), .RspErr(p0_err),
      .AluBusA(p0_a), .AluBusB(p0_b), .AluCtrl(p0_ctrl), .AluBusW(p0_aluw));

   alu_arbiter #(.FIXED_PRIO(1)) u_fx (
      .CLK(CLK), .Reset_L(Reset_L),
      .ReqValid0(ReqValid0), .ReqValid1(ReqValid1), .ReqReady0(p1_rdy0), .ReqReady1(p1_rdy1),
      .ReqA0(ReqA0), .ReqB0(ReqB0), .ReqA1(ReqA1), .ReqB1(ReqB1),
      .ReqCtrl0(ReqCtrl0), .ReqCtrl1(ReqCtrl1),
      .RspValid0(p1_rv0), .RspValid1(p1_rv1), .RspReady0(RspReady0), .RspReady1(RspReady1),
      .RspW(p1_w), .RspZero(p1_zero), .RspErr(p1_err),
      .AluBusA(p1_a), .AluBusB(p1_b), .AluCtrl(p1_ctrl), .AluBusW(p1_aluw));

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk1({tag, "_rdy0"}, p0_rdy0, 1'b0);
      chk1({tag, "_rdy1"}, p0_rdy1, 1'b0);
      chk1({tag, "_rv0"}, p0_rv0, 1'b0);
      chk1({tag, "_rv1"}, p0_rv1, 1'b0);
      chk64({tag, "_rspw"}, p0_w, 64'd0);
      chk1({tag, "_zero"}, p0_zero, 1'b1);
      chk1({tag, "_err"}, p0_err, 1'b0);
      chk64({tag, "_alua"}, p0_a, 64'd0);
      chk64({tag, "_alub"}, p0_b, 64'd0);
      chk64({tag, "_aluctrl"}, {60'd0, p0_ctrl}, 64'd0);
   endtask

   // One transaction on the round-robin instance; entered and left at posedge+1 in IDLE.
   task automatic do_op(input bit v0, input bit v1,
                        input logic [63:0] a0, input logic [63:0] b0, input logic [3:0] c0,
                        input logic [63:0] a1, input logic [63:0] b1, input logic [3:0] c1,
                        input int stall, input bit probe1);
      bit          own;
      logic [63:0] ew;
      logic        eerr;
      ReqValid0 = v0; ReqValid1 = v1;
      ReqA0 = a0; ReqB0 = b0; ReqCtrl0 = c0;
      ReqA1 = a1; ReqB1 = b1; ReqCtrl1 = c1;
      own = (v0 && v1) ? pref : v1;
      if (own) ref_op(c1, a1, b1, ew, eerr);
      else     ref_op(c0, a0, b0, ew, eerr);
      #1;
      chk1("grant_rdy0", p0_rdy0, !own);
      chk1("grant_rdy1", p0_rdy1, own);
      @(posedge CLK); #1;
      ReqValid0 = 1'b0; ReqValid1 = probe1;
      ReqA0 = {$urandom, $urandom}; ReqB0 = {$urandom, $urandom}; ReqCtrl0 = 4'($urandom);
      ReqA1 = {$urandom, $urandom}; ReqB1 = {$urandom, $urandom}; ReqCtrl1 = 4'($urandom);
      #1;
      chk1("exec_rdy0", p0_rdy0, 1'b0);
      chk1("exec_rdy1", p0_rdy1, 1'b0);
      chk1("exec_rv0", p0_rv0, 1'b0);
      chk1("exec_rv1", p0_rv1, 1'b0);
      @(posedge CLK); #1;
      chk1("rsp_rv0", p0_rv0, !own);
      chk1("rsp_rv1", p0_rv1, own);
      chk64("rsp_w", p0_w, ew);
      chk1("rsp_zero", p0_zero, ew == 64'd0);
      chk1("rsp_err", p0_err, eerr);
      for (int i = 0; i < stall; i++) begin
         RspReady0 = own; RspReady1 = !own;
         @(posedge CLK); #1;
         chk1("hold_rv", own ? p0_rv1 : p0_rv0, 1'b1);
         chk64("hold_w", p0_w, ew);
         chk1("hold_rdy0", p0_rdy0, 1'b0);
         chk1("hold_rdy1", p0_rdy1, 1'b0);
      end
      RspReady0 = !own; RspReady1 = own;
      @(posedge CLK); #1;
      RspReady0 = 1'b0; RspReady1 = 1'b0;
      ReqValid0 = 1'b0; ReqValid1 = 1'b0;
      chk1("done_rv0", p0_rv0, 1'b0);
      chk1("done_rv1", p0_rv1, 1'b0);
      pref = !own;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   logic [63:0] ra0, rb0, ra1, rb1, ew0, ew1;
   logic        ee0, ee1;
   logic [3:0]  codes [8];
   bit          rv0, rv1, own;

   initial begin
      codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b0011, 4'b1111};
      Reset_L = 1'b0;
      ReqValid0 = 1'b0; ReqValid1 = 1'b0; RspReady0 = 1'b0; RspReady1 = 1'b0;
      ReqA0 = '0; ReqB0 = '0; ReqA1 = '0; ReqB1 = '0; ReqCtrl0 = '0; ReqCtrl1 = '0;
      #12;
      chk_reset_vals("por");
      @(negedge CLK); Reset_L = 1'b1;
      @(posedge CLK); #1;
      pref = 1'b0;

      // single ADD, SUB to zero
      do_op(1, 0, 64'd5, 64'd3, 4'b0010, 64'd0, 64'd0, 4'b0000, 0, 0);
      do_op(0, 1, 64'd0, 64'd0, 4'b0000, 64'h1234, 64'h1234, 4'b0110, 0, 0);
      // backpressure on req0 with req1 waiting, then req1 served
      do_op(1, 0, 64'hFFFF_0000_1234_5678, 64'h0F0F_0F0F_0F0F_0F0F, 4'b0001, 64'd0, 64'd0, 4'b0000, 5, 1);
      do_op(0, 1, 64'd0, 64'd0, 4'b0000, 64'd100, 64'd1, 4'b0110, 0, 0);
      // bad code then ADD
      do_op(1, 0, 64'd7, 64'd9, 4'b1111, 64'd0, 64'd0, 4'b0000, 0, 0);
      do_op(1, 0, 64'd7, 64'd9, 4'b0010, 64'd0, 64'd0, 4'b0000, 0, 0);

      for (int n = 0; n < 24; n++) begin
         rv0 = 1'($urandom_range(0, 1));
         rv1 = rv0 ? 1'($urandom_range(0, 1)) : 1'b1;
         ra0 = {$urandom, $urandom};
         rb0 = ($urandom_range(0, 3) == 0) ? ra0 : {$urandom, $urandom};
         ra1 = {$urandom, $urandom};
         rb1 = ($urandom_range(0, 3) == 0) ? ra1 : {$urandom, $urandom};
         do_op(rv0, rv1, ra0, rb0, codes[$urandom_range(0, 7)], ra1, rb1, codes[$urandom_range(0, 7)],
               $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      // contention: both instances restarted together, both requesters always valid
      Reset_L = 1'b0; #3; Reset_L = 1'b1;
      @(posedge CLK); #1;
      pref = 1'b0;
      ra0 = {$urandom, $urandom}; rb0 = {$urandom, $urandom};
      ra1 = {$urandom, $urandom}; rb1 = {$urandom, $urandom};
      ReqA0 = ra0; ReqB0 = rb0; ReqCtrl0 = 4'b0010;
      ReqA1 = ra1; ReqB1 = rb1; ReqCtrl1 = 4'b0110;
      ref_op(4'b0010, ra0, rb0, ew0, ee0);
      ref_op(4'b0110, ra1, rb1, ew1, ee1);
      ReqValid0 = 1'b1; ReqValid1 = 1'b1; RspReady0 = 1'b1; RspReady1 = 1'b1;
      for (int k = 0; k < 6; k++) begin
         own = pref;
         #1;
         chk1("cont_rr_rdy0", p0_rdy0, !own);
         chk1("cont_rr_rdy1", p0_rdy1, own);
         chk1("cont_fx_rdy0", p1_rdy0, 1'b1);
         chk1("cont_fx_rdy1", p1_rdy1, 1'b0);
         @(posedge CLK); #1;
         @(posedge CLK); #1;
         chk1("cont_rr_rv1", p0_rv1, own);
         chk64("cont_rr_w", p0_w, own ? ew1 : ew0);
         chk1("cont_fx_rv0", p1_rv0, 1'b1);
         chk64("cont_fx_w", p1_w, ew0);
         @(posedge CLK); #1;
         pref = !own;
      end
      ReqValid0 = 1'b0; ReqValid1 = 1'b0; RspReady0 = 1'b0; RspReady1 = 1'b0;
      @(posedge CLK); #1;

      // reset while a response is pending
      ReqValid0 = 1'b1; ReqA0 = 64'd11; ReqB0 = 64'd22; ReqCtrl0 = 4'b0010;
      @(posedge CLK); #1;
      ReqValid0 = 1'b0;
      @(posedge CLK); #1;
      chk1("pre_rst_rv0", p0_rv0, 1'b1);
      chk64("pre_rst_w", p0_w, 64'd33);
      #2;
      Reset_L = 1'b0;
      #1;
      chk_reset_vals("rst_resp");
      @(posedge CLK); #1;
      Reset_L = 1'b1;
      pref = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK); #1;
         chk1("post_rst_rv0", p0_rv0, 1'b0);
         chk1("post_rst_rv1", p0_rv1, 1'b0);
      end
      do_op(1, 1, 64'd1, 64'd2, 4'b0000, 64'd3, 64'd4, 4'b0001, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
